// File: rtl/mcif_wr_burst_gen_pkg.sv
// Shared definitions for the MCIF write burst generator: bus widths, command packet layout
// and FSM encoding.
package mcif_wr_burst_gen_pkg;

  localparam int unsigned AXI_DATA_WIDTH           = 128;
  localparam int unsigned LOG2_MAX_BURST_ATOM_CUBE = 4;
  localparam int unsigned PAGE_BYTES               = 4096;
  localparam int unsigned PD_WIDTH                 = AXI_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCmd     = 2'd1,
    StData    = 2'd2,
    StWaitRsp = 2'd3
  } wr_state_e;

  function automatic logic [PD_WIDTH-1:0] mk_cmd_pd(
    input logic [31:0]                         addr,
    input logic [LOG2_MAX_BURST_ATOM_CUBE-1:0] len_m1,
    input logic                                noposted
  );
    logic [PD_WIDTH-1:0] pd;
    pd = '0;
    pd[PD_WIDTH-1]                                 = 1'b1;
    pd[LOG2_MAX_BURST_ATOM_CUBE+32]                = noposted;
    pd[LOG2_MAX_BURST_ATOM_CUBE+32-1:32]           = len_m1;
    pd[31:0]                                       = addr;
    return pd;
  endfunction

endpackage

// File: rtl/mcif_burst_len_calc.sv
// Beats in the next burst: min(remaining, MAX_BURST, beats left in the current 4KB page).
module mcif_burst_len_calc
  import mcif_wr_burst_gen_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BPB       = AXI_DATA_WIDTH / 8
) (
  input  logic [11:0]                  addr_off,
  input  logic [15:0]                  remaining,
  output logic [$clog2(MAX_BURST):0]   beats
);

  logic [12:0] page_left_bytes;
  logic [12:0] page_left_beats;
  logic [16:0] lim;

  always_comb begin
    page_left_bytes = 13'(PAGE_BYTES) - {1'b0, addr_off};
    page_left_beats = page_left_bytes / 13'(BPB);
    lim = 17'(MAX_BURST);
    if ({4'b0, page_left_beats} < lim) lim = {4'b0, page_left_beats};
    if ({1'b0, remaining} < lim) lim = {1'b0, remaining};
    beats = ($clog2(MAX_BURST) + 1)'(lim);
  end

endmodule

// File: rtl/mcif_wr_burst_gen.sv
// Splits a write transfer into 4KB-safe AXI bursts: one command packet per burst followed by
// its payload beats passed straight through from the data input.
module mcif_wr_burst_gen
  import mcif_wr_burst_gen_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BPB       = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [31:0]               req_addr,
  input  logic [15:0]               req_len,
  input  logic                      req_noposted,
  input  logic                      dat_vld,
  output logic                      dat_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] dat,
  output logic                      wr_req_vld,
  input  logic                      wr_req_rdy,
  output logic [PD_WIDTH-1:0]       wr_req_pd,
  input  logic                      wr_rsp_complete,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;

  wr_state_e     state_q;
  logic [31:0]   addr_q;
  logic [15:0]   rem_q;
  logic          noposted_q;
  logic [BW-1:0] beat_cnt_q;
  logic          done_q;

  logic [BW-1:0]       beats;
  logic                last_burst;
  logic                dat_hs;
  logic                last_beat;
  logic [PD_WIDTH-1:0] cmd_pd;

  mcif_burst_len_calc #(
    .MAX_BURST (MAX_BURST),
    .BPB       (BPB)
  ) u_len_calc (
    .addr_off  (addr_q[11:0]),
    .remaining (rem_q),
    .beats     (beats)
  );

  // addr_q/rem_q only move on the last beat, so the command stays stable while stalled.
  assign last_burst = (16'(beats) == rem_q);
  assign dat_hs     = (state_q == StData) && dat_vld && wr_req_rdy;
  assign last_beat  = dat_hs && (beat_cnt_q == beats - 1'b1);
  assign cmd_pd     = mk_cmd_pd(addr_q, LOG2_MAX_BURST_ATOM_CUBE'(beats - 1'b1),
                                noposted_q && last_burst);

  // Held low while done pulses so a new request is never taken in the done cycle.
  assign req_rdy    = rst_n && (state_q == StIdle) && !done_q;
  assign dat_rdy    = (state_q == StData) && wr_req_rdy;
  assign wr_req_vld = (state_q == StCmd) || ((state_q == StData) && dat_vld);
  assign wr_req_pd  = (state_q == StData) ? {1'b0, dat} : cmd_pd;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      noposted_q <= 1'b0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_vld && req_rdy) begin
            addr_q     <= req_addr;
            rem_q      <= req_len;
            noposted_q <= req_noposted;
            beat_cnt_q <= '0;
            state_q    <= StCmd;
          end
        end
        StCmd: begin
          if (wr_req_rdy) begin
            beat_cnt_q <= '0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (last_beat) begin
            addr_q     <= addr_q + 32'(beats) * 32'(BPB);
            rem_q      <= rem_q - 16'(beats);
            beat_cnt_q <= '0;
            if (!last_burst) begin
              state_q <= StCmd;
            end else if (noposted_q) begin
              state_q <= StWaitRsp;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end else if (dat_hs) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        StWaitRsp: begin
          if (wr_rsp_complete) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_len_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (req_vld && req_rdy) |-> (req_len != 16'd0));

endmodule

// File: tb/tb_mcif_wr_burst_gen.sv
// Scoreboard bench for mcif_wr_burst_gen: directed transfers with hand-computed bursts.
module tb_mcif_wr_burst_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic [31:0]  req_addr;
  logic [15:0]  req_len;
  logic         req_noposted;
  logic         dat_vld;
  logic         dat_rdy;
  logic [127:0] dat;
  logic         wr_req_vld;
  logic         wr_req_rdy;
  logic [128:0] wr_req_pd;
  logic         wr_rsp_complete;
  logic         busy;
  logic         done;

  mcif_wr_burst_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .req_noposted    (req_noposted),
    .dat_vld         (dat_vld),
    .dat_rdy         (dat_rdy),
    .dat             (dat),
    .wr_req_vld      (wr_req_vld),
    .wr_req_rdy      (wr_req_rdy),
    .wr_req_pd       (wr_req_pd),
    .wr_rsp_complete (wr_rsp_complete),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_dat_cyc = -10;
  int           dat_hs_cnt   = 0;
  int           dat_idx      = 0;
  int           exp_dat_idx  = 0;
  bit           stall        = 0;
  logic [128:0] sb[$];

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] mk_dat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v ^ 32'hA500_0000, ~v, v * 32'd3, 32'hC0DE_0000 + v};
  endfunction

  // Command layout: bit128=1, bit36=noposted, [35:32]=beats-1, [31:0]=addr.
  task automatic push_burst(input logic [31:0] a, input logic [3:0] len_m1, input logic np);
    logic [128:0] c;
    c = '0;
    c[128] = 1'b1;
    c[36] = np;
    c[35:32] = len_m1;
    c[31:0] = a;
    sb.push_back(c);
    for (int j = 0; j <= int'(len_m1); j++) begin
      sb.push_back({1'b0, mk_dat(exp_dat_idx)});
      exp_dat_idx++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Payload/ready driver; dat_vld stays up until its beat is taken.
  initial begin
    bit hs;
    dat_vld = 1'b0;
    wr_req_rdy = 1'b0;
    dat = '0;
    forever begin
      @(negedge clk);
      hs = dat_vld && dat_rdy;
      @(posedge clk);
      #1;
      if (hs) dat_idx++;
      if (!(dat_vld && !hs)) dat_vld = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      dat = mk_dat(dat_idx);
      wr_req_rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write-port handshake.
  initial begin
    bit           prev_cmd_stall;
    logic [128:0] prev_pd;
    logic [128:0] exp;
    prev_cmd_stall = 0;
    prev_pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_cmd_stall) begin
          check("cmd_hold_vld", 129'(wr_req_vld), 129'(1));
          check("cmd_hold_pd", wr_req_pd, prev_pd);
        end
        if (!busy) check("idle_quiet", 129'({wr_req_vld, dat_rdy}), 129'(0));
        if (wr_req_vld && wr_req_rdy) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pkt: got %h, expected no packet (cycle %0d)", wr_req_pd, cyc);
          end else begin
            exp = sb.pop_front();
            check("pkt", wr_req_pd, exp);
          end
          if (!wr_req_pd[128]) begin
            last_dat_cyc = cyc;
            dat_hs_cnt++;
          end
        end
        prev_cmd_stall = wr_req_vld && !wr_req_rdy && wr_req_pd[128];
        prev_pd = wr_req_pd;
      end else begin
        prev_cmd_stall = 0;
      end
    end
  end

  task automatic issue_req(input logic [31:0] a, input logic [15:0] len, input logic np);
    bit ok;
    ok = 0;
    @(negedge clk);
    req_vld = 1'b1;
    req_addr = a;
    req_len = len;
    req_noposted = np;
    for (int k = 0; k < 100; k++) begin
      if (req_rdy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: got req_rdy=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] a, input logic [15:0] len, input logic np,
                          input bit spur, input string name);
    bit got;
    int done_cyc;
    int rsp_cyc;
    int idle_wait;
    got = 0;
    done_cyc = -1;
    rsp_cyc = -1;
    idle_wait = 0;
    issue_req(a, len, np);
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      wr_rsp_complete = 1'b0;
      if (done) begin
        got = 1;
        done_cyc = cyc;
        break;
      end
      if (spur && k == 6) wr_rsp_complete = 1'b1;
      if (np && sb.size() == 0 && rsp_cyc < 0) begin
        idle_wait++;
        if (idle_wait == 4) begin
          wr_rsp_complete = 1'b1;
          rsp_cyc = cyc;
        end
      end
    end
    wr_rsp_complete = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected done pulse", name);
    end else begin
      if (np) check({name, "_done_after_rsp"}, 129'(done_cyc), 129'(rsp_cyc + 1));
      else    check({name, "_done_after_last"}, 129'(done_cyc), 129'(last_dat_cyc + 1));
      check({name, "_sb_empty"}, 129'(sb.size()), 129'(0));
      check({name, "_rdy_in_done"}, 129'(req_rdy), 129'(0));
      @(negedge clk);
      check({name, "_done_width"}, 129'(done), 129'(0));
      check({name, "_rdy_after"}, 129'(req_rdy), 129'(1));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_rdy"}, 129'(req_rdy), 129'(0));
    check({name, "_wr_req_vld"}, 129'(wr_req_vld), 129'(0));
    check({name, "_dat_rdy"}, 129'(dat_rdy), 129'(0));
    check({name, "_busy"}, 129'(busy), 129'(0));
    check({name, "_done"}, 129'(done), 129'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req_vld = 1'b0;
    req_addr = '0;
    req_len = '0;
    req_noposted = 1'b0;
    wr_rsp_complete = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy_after", 129'(req_rdy), 129'(1));

    // 40 beats from 0: 16+16+8.
    push_burst(32'h0000_0000, 4'd15, 1'b0);
    push_burst(32'h0000_0100, 4'd15, 1'b0);
    push_burst(32'h0000_0200, 4'd7,  1'b0);
    run_xfer(32'h0000_0000, 16'd40, 1'b0, 1'b0, "len40");

    // 0xFC0: only 4 beats fit before the 4KB boundary.
    push_burst(32'h0000_0FC0, 4'd3, 1'b0);
    push_burst(32'h0000_1000, 4'd5, 1'b0);
    run_xfer(32'h0000_0FC0, 16'd10, 1'b0, 1'b0, "page");

    // Non-posted: only the final command carries noposted.
    push_burst(32'h0000_0100, 4'd15, 1'b0);
    push_burst(32'h0000_0200, 4'd3,  1'b1);
    run_xfer(32'h0000_0100, 16'd20, 1'b1, 1'b0, "noposted");

    // Address wraps modulo 2^32.
    push_burst(32'hFFFF_FFE0, 4'd1, 1'b0);
    push_burst(32'h0000_0000, 4'd1, 1'b0);
    run_xfer(32'hFFFF_FFE0, 16'd4, 1'b0, 1'b0, "wrap");

    // Random 50% stalls on both sides, page split at 0x3F80.
    stall = 1;
    push_burst(32'h0000_3F80, 4'd7,  1'b0);
    push_burst(32'h0000_4000, 4'd15, 1'b0);
    push_burst(32'h0000_4100, 4'd0,  1'b0);
    run_xfer(32'h0000_3F80, 16'd25, 1'b0, 1'b0, "stall");
    stall = 0;
    repeat (2) @(negedge clk);

    // Spurious completion during a posted transfer is ignored.
    push_burst(32'h0000_0500, 4'd15, 1'b0);
    run_xfer(32'h0000_0500, 16'd16, 1'b0, 1'b1, "spurious");

    // Reset in the middle of a data burst.
    begin
      int base;
      bit reached;
      base = dat_hs_cnt;
      reached = 0;
      push_burst(32'h0000_0000, 4'd15, 1'b0);
      issue_req(32'h0000_0000, 16'd40, 1'b0);
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (dat_hs_cnt >= base + 5) begin
          reached = 1;
          break;
        end
      end
      if (!reached) begin
        n_checks++;
        n_fail++;
        $display("FAIL midrst_reach: got %0d beats, expected at least 5", dat_hs_cnt - base);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("midrst_busy_before_release", 129'(busy), 129'(0));
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_dat_idx = dat_idx;
      repeat (4) @(negedge clk);
      check("midrst_idle", 129'(busy), 129'(0));
      push_burst(32'h0000_2000, 4'd2, 1'b1);
      run_xfer(32'h0000_2000, 16'd3, 1'b1, 1'b0, "after_rst");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected completion before 500000");
    $fatal(1, "global timeout");
  end

endmodule
